// File: rtl/wave_sel_xfade.sv
// wave_sel_xfade: registered N-way waveform selector for the DDS output path.
// A select change fades the active channel down to midscale, swaps to the
// requested channel, then fades the new channel back up, so switching never
// clicks. Everything advances only on the sample-rate strobe.
//
// Handshake: out_valid is a one-cycle pulse, issued the cycle after each
// sample_en strobe, marking that out holds a new sample. There is no
// back-pressure. Between strobes, out holds its value and out_valid stays low.
module wave_sel_xfade #(
    parameter int M    = 12,
    parameter int N    = 5,
    parameter int SELW = 3,
    parameter int G    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N*M-1:0]    in_bus,
    input  logic [SELW-1:0]   sel,
    input  logic              sample_en,
    output logic [M-1:0]      out,
    output logic              out_valid,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_STEADY   = 2'd0,
        ST_FADE_OUT = 2'd1,
        ST_FADE_IN  = 2'd2
    } state_t;

    localparam logic [M-1:0] MID      = {1'b1, {(M-1){1'b0}}};
    localparam logic [G:0]   GAIN_MAX = {1'b1, {G{1'b0}}};
    localparam logic [G:0]   GAIN_ONE = {{G{1'b0}}, 1'b1};
    localparam logic [G:0]   GAIN_MIN = '0;

    state_t          r_state;
    logic [SELW-1:0] r_cur;
    logic [SELW-1:0] r_tgt;
    logic [G:0]      r_gain;
    logic [M-1:0]    r_out;
    logic            r_out_valid;

    state_t              w_state_nxt;
    logic [SELW-1:0]     w_cur_nxt;
    logic [G:0]          w_gain_nxt;
    logic [SELW-1:0]     w_tgt_nxt;
    logic                w_sel_ok;
    logic [M-1:0]        w_in_k;
    logic signed [M:0]   w_d;
    logic signed [M+G+1:0] w_d_ext;
    logic signed [M+G+1:0] w_g_ext;
    logic signed [M+G+1:0] w_p;
    logic signed [M+G+1:0] w_p_sh;
    logic [M-1:0]        w_out;

    // Out-of-range selects leave the pending target untouched.
    assign w_sel_ok  = ({1'b0, sel} < (SELW+1)'(N));
    assign w_tgt_nxt = w_sel_ok ? sel : r_tgt;

    // Pick the active channel's sample out of the flat input bus.
    always_comb begin
        w_in_k = MID;
        for (int k = 0; k < N; k++) begin
            if (r_cur == SELW'(k)) begin
                w_in_k = in_bus[k*M +: M];
            end
        end
    end

    // Scale the offset from midscale by gain/2**G; the arithmetic shift
    // rounds toward -inf, and |gain| <= 1 keeps the sum inside M bits.
    assign w_d     = $signed({1'b0, w_in_k}) - $signed({1'b0, MID});
    assign w_d_ext = {{(G+1){w_d[M]}}, w_d};
    assign w_g_ext = {{(M+1){1'b0}}, r_gain};
    assign w_p     = w_d_ext * w_g_ext;
    assign w_p_sh  = w_p >>> G;
    assign w_out   = MID + w_p_sh[M-1:0];

    // Fade sequencing: the decision uses the target captured on this strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_gain_nxt  = r_gain;
        case (r_state)
            ST_STEADY: begin
                w_gain_nxt = GAIN_MAX;
                if (w_tgt_nxt != r_cur) begin
                    w_state_nxt = ST_FADE_OUT;
                    w_gain_nxt  = GAIN_MAX - GAIN_ONE;
                end
            end
            ST_FADE_OUT: begin
                if (r_gain == GAIN_MIN) begin
                    // Swap at silence; the latest target wins.
                    w_cur_nxt   = w_tgt_nxt;
                    w_state_nxt = ST_FADE_IN;
                end else begin
                    w_gain_nxt = r_gain - GAIN_ONE;
                end
            end
            ST_FADE_IN: begin
                if (w_tgt_nxt != r_cur) begin
                    // Reverse from the present gain so the output stays continuous.
                    w_state_nxt = ST_FADE_OUT;
                    if (r_gain != GAIN_MIN) begin
                        w_gain_nxt = r_gain - GAIN_ONE;
                    end
                end else begin
                    w_gain_nxt = r_gain + GAIN_ONE;
                    if ((r_gain + GAIN_ONE) == GAIN_MAX) begin
                        w_state_nxt = ST_STEADY;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_STEADY;
                w_gain_nxt  = GAIN_MAX;
            end
        endcase
    end

    // State, selection and output registers; only strobes move them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_STEADY;
            r_cur       <= '0;
            r_tgt       <= '0;
            r_gain      <= GAIN_MAX;
            r_out       <= MID;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= sample_en;
            if (sample_en) begin
                r_out   <= w_out;
                r_tgt   <= w_tgt_nxt;
                r_cur   <= w_cur_nxt;
                r_gain  <= w_gain_nxt;
                r_state <= w_state_nxt;
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign busy      = (r_state != ST_STEADY);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_wave_sel_xfade.sv
// Bench for wave_sel_xfade: directed fade scenarios plus random traffic,
// checked against a behavioural model through an expected-value queue.
module tb_wave_sel_xfade;
  localparam int M    = 12;
  localparam int N    = 5;
  localparam int SELW = 3;
  localparam int G    = 4;
  localparam int MID  = 2048;
  localparam int GMAX = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N*M-1:0] in_bus = '0;
  logic [SELW-1:0] sel = '0;
  logic sample_en = 1'b0;
  logic [M-1:0] out;
  logic out_valid;
  logic busy;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  wave_sel_xfade #(.M(M), .N(N), .SELW(SELW), .G(G)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_bus(in_bus),
    .sel(sel),
    .sample_en(sample_en),
    .out(out),
    .out_valid(out_valid),
    .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad = 0;
  logic [M:0] exp_q[$];   // {busy, out}
  int ch_val[N];
  int sel_val = 0;

  // Behavioural model: active channel, pending target, gain and fade phase
  // (0 = steady, 1 = fading down, 2 = fading up).
  int m_cur = 0;
  int m_tgt = 0;
  int m_gain = GMAX;
  int m_phase = 0;

  int last_out = MID;
  bit rst_q = 1'b0;

  function automatic void check(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Midscale plus (sample - midscale) * gain / 2**G, floored.
  function automatic int scaled(int sample, int gain);
    int prod;
    int q;
    prod = (sample - MID) * gain;
    if (prod >= 0) q = prod / GMAX;
    else q = -((-prod + GMAX - 1) / GMAX);
    return MID + q;
  endfunction

  function automatic void model_reset();
    m_cur = 0;
    m_tgt = 0;
    m_gain = GMAX;
    m_phase = 0;
  endfunction

  function automatic void model_step();
    int e;
    logic [M:0] item;
    e = scaled(ch_val[m_cur], m_gain);
    if (sel_val < N) m_tgt = sel_val;
    case (m_phase)
      0: if (m_tgt != m_cur) begin m_phase = 1; m_gain = m_gain - 1; end
      1: begin
        if (m_gain == 0) begin m_cur = m_tgt; m_phase = 2; end
        else m_gain = m_gain - 1;
      end
      default: begin
        if (m_tgt != m_cur) begin
          m_phase = 1;
          if (m_gain > 0) m_gain = m_gain - 1;
        end else begin
          m_gain = m_gain + 1;
          if (m_gain == GMAX) m_phase = 0;
        end
      end
    endcase
    item = {(m_phase != 0), M'(e)};
    exp_q.push_back(item);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_inputs();
    for (int k = 0; k < N; k++) in_bus[k*M +: M] = M'(ch_val[k]);
    sel = SELW'(sel_val);
  endtask

  // Idle cycles carry garbage on in_bus/sel, which must be ignored.
  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      sample_en = 1'b0;
      for (int k = 0; k < N; k++) in_bus[k*M +: M] = M'($urandom);
      sel = SELW'($urandom);
    end
  endtask

  task automatic strobe(int gaps);
    idle(gaps);
    @(negedge clk);
    apply_inputs();
    sample_en = 1'b1;
    model_step();
  endtask

  task automatic strobes(int n);
    repeat (n) strobe(0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    sample_en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check("rst_out", int'(out), MID);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(out_valid), 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) rst_q = rst_n;

  initial begin
    logic [M:0] e;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got out=%0d expected no output", out);
        end else begin
          e = exp_q.pop_front();
          check("out", int'(out), int'(e[M-1:0]));
          check("busy", int'(busy), int'(e[M]));
        end
      end else if (rst_q) begin
        check("hold", int'(out), last_out);
      end
      last_out = int'(out);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int k = 0; k < N; k++) ch_val[k] = 100 * (k + 1);

    // Reset, then check the state before any strobe.
    ch_val[0] = 3000;
    apply_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("init_out", int'(out), MID);
    check("init_busy", int'(busy), 0);
    check("init_valid", int'(out_valid), 0);
    rst_n = 1'b1;
    strobe(1);
    idle(2);

    // Full switch ch0 (4095) -> ch3 (0), with full-scale extremes.
    ch_val[0] = 4095;
    ch_val[3] = 0;
    sel_val = 3;
    strobes(36);
    idle(2);

    // Move to ch1, then an invalid select must not start a fade.
    sel_val = 1;
    strobes(35);
    sel_val = 6;
    for (int i = 0; i < 10; i++) begin
      ch_val[1] = $urandom_range(0, 4095);
      strobe($urandom_range(0, 2));
    end
    sel_val = 2;
    strobes(35);

    // Retarget during fade-in at gain 5.
    ch_val[2] = 500;
    ch_val[3] = 3900;
    ch_val[1] = 1000;
    sel_val = 3;
    strobes(22);
    sel_val = 1;
    strobes(40);

    // Several retargets during one fade-out; ch4 has a distinct value.
    sel_val = 0;
    strobes(35);
    ch_val[0] = 3500;
    ch_val[4] = 1234;
    ch_val[2] = 700;
    sel_val = 1; strobes(3);
    sel_val = 4; strobes(3);
    sel_val = 2; strobes(40);

    // Retarget back to the active channel mid fade-out.
    sel_val = 0; strobes(5);
    sel_val = 2; strobes(36);

    // Reset in the middle of a fade, then confirm ch0 is active.
    sel_val = 3;
    strobes(7);
    idle(1);
    do_reset();
    sel_val = 0;
    ch_val[0] = 111;
    strobe(0);
    strobe(1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) sel_val = $urandom_range(0, 7);
      for (int k = 0; k < N; k++) begin
        case ($urandom_range(0, 3))
          0: ch_val[k] = 0;
          1: ch_val[k] = 4095;
          default: ch_val[k] = $urandom_range(0, 4095);
        endcase
      end
      strobe($urandom_range(0, 2));
    end

    idle(4);
    check("drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
